free_list: RTL

//  Circular FIFO of free physical-register tags for the rename stage.

---
 rtl/free_list.sv | 91 +++++++++
 1 files changed

// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags feeding rename/dispatch.
// Hands out up to two tags per cycle and takes back up to two retired tags per cycle.
module free_list #(
    parameter int unsigned NUM_PR = 64,
    parameter int unsigned NUM_AR = 32,
    parameter int unsigned TAG_W  = 7,
    parameter int unsigned DEPTH  = NUM_PR - NUM_AR
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       rs_mt_fl_dispatch_num,
    input  logic [1:0]       fl_retire_num,
    input  logic [TAG_W-1:0] fl_retire_tag_a,
    input  logic [TAG_W-1:0] fl_retire_tag_b,
    output logic [TAG_W-1:0] fl_pr0,
    output logic [TAG_W-1:0] fl_pr1,
    output logic [1:0]       fl_avail,
    output logic [5:0]       fl_count,
    output logic             fl_error
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [TAG_W-1:0] list_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             error_q, error_d;

    logic [PtrW-1:0]  head_p1, tail_p1;
    logic [CntW-1:0]  n_ext, m_ext;
    logic [CntW:0]    count_plus_m;
    logic             alloc_ok, free_ok;

    assign head_p1 = head_q + PtrW'(1);
    assign tail_p1 = tail_q + PtrW'(1);
    assign n_ext   = CntW'(rs_mt_fl_dispatch_num);
    assign m_ext   = CntW'(fl_retire_num);
    assign count_plus_m = {1'b0, count_q} + {1'b0, m_ext};

    // Both operations are judged against the pre-cycle count; no bypass between them.
    always_comb begin
        alloc_ok = (rs_mt_fl_dispatch_num != 2'd3) && (n_ext <= count_q);
        free_ok  = (fl_retire_num != 2'd3) && (count_plus_m <= (CntW + 1)'(DEPTH));
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (alloc_ok) begin
            head_d  = head_q + PtrW'(rs_mt_fl_dispatch_num);
            count_d = count_d - n_ext;
        end
        if (free_ok) begin
            tail_d  = tail_q + PtrW'(fl_retire_num);
            count_d = count_d + m_ext;
        end
        error_d = !alloc_ok || !free_ok;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CntW'(DEPTH);
            error_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                list_q[i] <= TAG_W'(NUM_AR + i);
            end
        end else if (free_ok) begin
            if (fl_retire_num >= 2'd1) list_q[tail_q]  <= fl_retire_tag_a;
            if (fl_retire_num == 2'd2) list_q[tail_p1] <= fl_retire_tag_b;
        end
    end

    assign fl_pr0   = list_q[head_q];
    assign fl_pr1   = list_q[head_p1];
    assign fl_avail = (count_q >= CntW'(2)) ? 2'd2 : count_q[1:0];
    assign fl_count = 6'(count_q);
    assign fl_error = error_q;

endmodule
